// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: beat, requester id, read tag and lock state.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package mem_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0] mem_beat_t;
  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  req_id_t      ptr,
  output logic [N-1:0] gnt,
  output req_id_t      gnt_id,
  output logic         any
);
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (j == (int'(ptr) + k) % N)) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          gnt_id = req_id_t'(j);
        end
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port; reads are tagged through the fixed latency.
// Optional ownership lock enabled by defining MEM_ARB_LOCK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][`ADDR_WIDTH-1:0] req_addr,
  input  mem_beat_t [NUM_REQ-1:0]             req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                  req_lock,
`endif
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output mem_beat_t                           rsp_data,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [`ADDR_WIDTH-1:0]              mem_address,
  output mem_beat_t                           mem_writedata,
  input  mem_beat_t                           mem_readdata
);
  req_id_t                  ptr, gnt_id, ptr_nxt;
  logic [NUM_REQ-1:0]       req_mask, gnt;
  logic                     any_gnt, lock_hold;
  logic                     sel_write;
  logic [`ADDR_WIDTH-1:0]   sel_addr;
  mem_beat_t                sel_wdata;
  tag_t                     vld_pipe [READ_LATENCY:0];

`ifdef MEM_ARB_LOCK_EN
  arb_state_t         state;
  logic [NUM_REQ-1:0] owner_oh;

  assign lock_hold = (state == ARB_LOCKED) && |(req_lock & owner_oh);
  assign req_mask  = lock_hold ? (req_valid & owner_oh) : req_valid;

  // The lock-drop cycle arbitrates normally and may hand the lock straight to a new owner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      owner_oh <= '0;
    end else if (!lock_hold) begin
      if (any_gnt && |(gnt & req_lock)) begin
        state    <= ARB_LOCKED;
        owner_oh <= gnt;
      end else begin
        state <= ARB_IDLE;
      end
    end
  end
`else
  assign lock_hold = 1'b0;
  assign req_mask  = req_valid;
`endif

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req_mask),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any_gnt)
  );

  assign req_ready = gnt;
  assign ptr_nxt   = (gnt_id == req_id_t'(NUM_REQ-1)) ? '0 : req_id_t'(gnt_id + 1'b1);

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt[j]) begin
        sel_write = req_write[j];
        sel_addr  = req_addr[j];
        sel_wdata = req_wdata[j];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      ptr           <= '0;
    end else begin
      mem_read  <= any_gnt & ~sel_write;
      mem_write <= any_gnt & sel_write;
      if (any_gnt) begin
        mem_address   <= sel_addr;
        mem_writedata <= sel_wdata;
        if (!lock_hold) ptr <= ptr_nxt;
      end
    end
  end

  // Stage k holds the tag of the read whose data is due k cycles after its issue cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= READ_LATENCY; k++) vld_pipe[k] <= '0;
    end else begin
      vld_pipe[0] <= '{valid: any_gnt & ~sel_write, id: gnt_id};
      for (int k = 1; k <= READ_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_rsp
    assign rsp_valid[r] = vld_pipe[READ_LATENCY].valid &&
                          (vld_pipe[READ_LATENCY].id == req_id_t'(r));
  end

  assign rsp_data = vld_pipe[READ_LATENCY].valid ? mem_readdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (read latency 1 and 3) share directed stimulus.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int NR = 2;
  localparam int NI = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [NR-1:0]                  req_valid, req_write, req_lock;
  logic [NR-1:0][`ADDR_WIDTH-1:0] req_addr;
  mem_beat_t [NR-1:0]             req_wdata;

  logic [NR-1:0]          req_ready [NI];
  logic [NR-1:0]          rsp_valid [NI];
  mem_beat_t              rsp_data [NI];
  mem_beat_t              mem_writedata [NI];
  mem_beat_t              mem_readdata [NI];
  logic                   mem_read [NI];
  logic                   mem_write [NI];
  logic [`ADDR_WIDTH-1:0] mem_address [NI];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int        id;
    mem_beat_t data;
    int        due;
  } exp_t;
  exp_t expq [NI][$];

  mem_beat_t shadow [256];

  logic                   p_chk = 1'b0;
  logic                   p_rd, p_wr;
  logic [`ADDR_WIDTH-1:0] p_addr;
  mem_beat_t              p_wd;

  function automatic mem_beat_t init_word(int a);
    return mem_beat_t'(32'hC0DE_0000 + a);
  endfunction

  function automatic int lat(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  always @(posedge clock) cyc++;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int RL = (g == 0) ? 1 : 3;
    mem_beat_t mem [256];
    bit        wr_seen [256];
    mem_beat_t rd_pipe [RL];

    mem_port_arbiter #(.NUM_REQ(NR), .READ_LATENCY(RL)) u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready[g]),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
`ifdef MEM_ARB_LOCK_EN
      .req_lock      (req_lock),
`endif
      .rsp_valid     (rsp_valid[g]),
      .rsp_data      (rsp_data[g]),
      .mem_read      (mem_read[g]),
      .mem_write     (mem_write[g]),
      .mem_address   (mem_address[g]),
      .mem_writedata (mem_writedata[g]),
      .mem_readdata  (mem_readdata[g])
    );

    // Memory: unwritten words read back as init_word(addr).
    always @(posedge clock) begin
      if (mem_write[g]) begin
        mem[mem_address[g][7:0]]     <= mem_writedata[g];
        wr_seen[mem_address[g][7:0]] <= 1'b1;
      end
      if (mem_read[g])
        rd_pipe[0] <= wr_seen[mem_address[g][7:0]] ? mem[mem_address[g][7:0]]
                                                   : init_word(int'(mem_address[g][7:0]));
      else
        rd_pipe[0] <= '0;
      for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_readdata[g] = rd_pipe[RL-1];

    always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
        while (expq[g].size() > 0 && expq[g][0].due < cyc) begin
          e = expq[g].pop_front();
          n_chk++; n_fail++;
          $display("FAIL rsp_missing[%0d] cyc=%0d got none, required id=%0d due=%0d", g, cyc, e.id, e.due);
        end
        n_chk++;
        if (rsp_valid[g] != '0) begin
          if (expq[g].size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected[%0d] cyc=%0d rsp_valid=%b required 00", g, cyc, rsp_valid[g]);
          end else begin
            e = expq[g].pop_front();
            if (rsp_valid[g] !== NR'(1 << e.id) || rsp_data[g] !== e.data || e.due != cyc) begin
              n_fail++;
              $display("FAIL rsp[%0d] cyc=%0d valid=%b data=%h, required valid=%b data=%h cyc=%0d",
                       g, cyc, rsp_valid[g], rsp_data[g], NR'(1 << e.id), e.data, e.due);
            end
          end
        end else if (rsp_data[g] !== '0) begin
          n_fail++;
          $display("FAIL rsp_idle_data[%0d] cyc=%0d data=%h required 0", g, cyc, rsp_data[g]);
        end
      end
    end
  end

  task automatic check_issue();
    if (!p_chk) return;
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (mem_read[g] !== p_rd || mem_write[g] !== p_wr) begin
        n_fail++;
        $display("FAIL issue_strobe[%0d] cyc=%0d rd,wr=%b%b required %b%b", g, cyc,
                 mem_read[g], mem_write[g], p_rd, p_wr);
      end
      if (p_rd || p_wr) begin
        n_chk++;
        if (mem_address[g] !== p_addr) begin
          n_fail++;
          $display("FAIL issue_addr[%0d] cyc=%0d addr=%h required %h", g, cyc, mem_address[g], p_addr);
        end
      end
      if (p_wr) begin
        n_chk++;
        if (mem_writedata[g] !== p_wd) begin
          n_fail++;
          $display("FAIL issue_wdata[%0d] cyc=%0d wdata=%h required %h", g, cyc, mem_writedata[g], p_wd);
        end
      end
    end
  endtask

  // One cycle of stimulus; eg is the hand-computed grant for this cycle.
  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] w, input logic [NR-1:0] lk,
                       input logic [NR-1:0] eg, input logic [`ADDR_WIDTH-1:0] a0,
                       input logic [`ADDR_WIDTH-1:0] a1, input mem_beat_t d0, input mem_beat_t d1);
    exp_t e;
    int   id;
    @(negedge clock);
    check_issue();
    req_valid = v; req_write = w; req_lock = lk;
    req_addr[0] = a0; req_addr[1] = a1;
    req_wdata[0] = d0; req_wdata[1] = d1;
    #1;
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (req_ready[g] !== eg) begin
        n_fail++;
        $display("FAIL grant[%0d] cyc=%0d req_ready=%b required %b", g, cyc, req_ready[g], eg);
      end
    end
    p_chk = 1'b1;
    p_rd = 1'b0; p_wr = 1'b0;
    if (eg != '0) begin
      id     = eg[0] ? 0 : 1;
      p_addr = id == 0 ? a0 : a1;
      p_wd   = id == 0 ? d0 : d1;
      p_wr   = w[id];
      p_rd   = ~w[id];
      if (p_wr) begin
        shadow[p_addr[7:0]] = p_wd;
      end else begin
        for (int g = 0; g < NI; g++) begin
          e.id = id; e.data = shadow[p_addr[7:0]]; e.due = cyc + 1 + lat(g);
          expq[g].push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic check_rst_outputs(input string tag);
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (mem_read[g] !== 1'b0 || mem_write[g] !== 1'b0 || mem_address[g] !== '0 ||
          mem_writedata[g] !== '0 || rsp_valid[g] !== '0 || rsp_data[g] !== '0 || req_ready[g] !== '0) begin
        n_fail++;
        $display("FAIL %s[%0d] rd=%b wr=%b addr=%h wd=%h rspv=%b rspd=%h rdy=%b required all 0",
                 tag, g, mem_read[g], mem_write[g], mem_address[g], mem_writedata[g],
                 rsp_valid[g], rsp_data[g], req_ready[g]);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req_valid = '0; req_lock = '0;
    p_chk = 1'b0;
    for (int g = 0; g < NI; g++) expq[g].delete();
    repeat (2) @(negedge clock);
    #1;
    check_rst_outputs("reset_mid");
    reset_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) shadow[a] = init_word(a);
    req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;

    repeat (3) @(negedge clock);
    #1;
    check_rst_outputs("reset_hold");
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check_rst_outputs("reset_release");

    // Single read by req0 of address 10.
    drive(2'b01, 2'b00, 2'b00, 2'b01, 16'd10, 16'd0, '0, '0);
    idle(6);

    // Reset while a read is in flight: its response must never appear.
    drive(2'b01, 2'b00, 2'b00, 2'b01, 16'd12, 16'd0, '0, '0);
    pulse_reset();
    idle(6);

    // Contention from pointer 0: strict alternation.
    repeat (3) begin
      drive(2'b11, 2'b00, 2'b00, 2'b01, 16'd20, 16'd30, '0, '0);
      drive(2'b11, 2'b00, 2'b00, 2'b10, 16'd20, 16'd30, '0, '0);
    end
    idle(6);

    // Write by req1 then read by req0 of the same address.
    drive(2'b10, 2'b10, 2'b00, 2'b10, 16'd0, 16'd40, '0, mem_beat_t'(32'hDEAD_BEEF));
    drive(2'b01, 2'b00, 2'b00, 2'b01, 16'd40, 16'd0, '0, '0);
    idle(6);

    // Back-to-back reads, addresses 0..7, lone requester granted every cycle.
    for (int a = 0; a < 8; a++)
      drive(2'b01, 2'b00, 2'b00, 2'b01, 16'(a), 16'd0, '0, '0);
    idle(8);

`ifdef MEM_ARB_LOCK_EN
    pulse_reset();
    repeat (3) drive(2'b11, 2'b00, 2'b01, 2'b01, 16'd50, 16'd60, '0, '0);
    drive(2'b11, 2'b00, 2'b00, 2'b10, 16'd50, 16'd60, '0, '0);
    drive(2'b11, 2'b00, 2'b00, 2'b01, 16'd50, 16'd60, '0, '0);
    idle(8);
`endif

    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (expq[g].size() != 0) begin
        n_fail++;
        $display("FAIL drain[%0d] pending=%0d required 0", g, expq[g].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
